// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole game engine.
package mole_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        UP,
        HIT,
        MISS,
        DONE
    } state_e;

    // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Fibonacci LFSR with load-on-reset seed; exposes the low OUT_W bits.
module mole_lfsr
    import mole_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [OUT_W-1:0] value
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/mole_game_engine.sv
// Whack-a-mole controller: spawns moles at pseudo-random positions, scores
// switch toggles against the lit mole, and tracks lives until win or loss.
module mole_game_engine
    import mole_pkg::*;
#(
    parameter int          N_MOLES   = 16,
    parameter int          SCORE_W   = 6,
    parameter int          WIN_SCORE = 32,
    parameter int          MOLE_TIME = 100_000_000,
    parameter int          LIVES     = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N_MOLES-1:0] sw,
    output logic [N_MOLES-1:0] led,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         lives_left,
    output logic               game_over,
    output logic               win
);

    localparam int IDX_W   = clog2(N_MOLES);
    localparam int TIMER_W = (clog2(MOLE_TIME) < 1) ? 1 : clog2(MOLE_TIME);

    state_e              state_q, state_d;
    logic [N_MOLES-1:0]  sw_s1_q, sw_s1_d;
    logic [N_MOLES-1:0]  sw_s2_q, sw_s2_d;
    logic [N_MOLES-1:0]  sw_prev_q, sw_prev_d;
    logic [IDX_W-1:0]    cur_idx_q, cur_idx_d;
    logic [IDX_W-1:0]    prev_idx_q, prev_idx_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [2:0]          lives_q, lives_d;
    logic                win_q, win_d;

    logic [IDX_W-1:0]    raw_idx;
    logic [IDX_W-1:0]    spawn_idx;
    logic [N_MOLES-1:0]  toggle;
    logic [N_MOLES-1:0]  cur_mask;
    logic [SCORE_W-1:0]  score_inc;
    logic                wrong_hit;
    logic                right_hit;
    logic                timed_out;

    mole_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (IDX_W)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .value (raw_idx)
    );

    always_comb begin
        sw_s1_d   = sw;
        sw_s2_d   = sw_s1_q;
        sw_prev_d = sw_s2_q;
    end

    assign toggle    = sw_s2_q ^ sw_prev_q;
    assign cur_mask  = {{(N_MOLES-1){1'b0}}, 1'b1} << cur_idx_q;
    assign wrong_hit = |(toggle & ~cur_mask);
    assign right_hit = |(toggle & cur_mask);
    assign timed_out = (timer_q == TIMER_W'(MOLE_TIME - 1));
    assign score_inc = score_q + SCORE_W'(1);

    // Fold the LFSR slice into range, then never repeat the previous position.
    always_comb begin
        spawn_idx = raw_idx;
        if (int'(raw_idx) >= N_MOLES) begin
            spawn_idx = raw_idx - IDX_W'(N_MOLES);
        end
        if (spawn_idx == prev_idx_q) begin
            spawn_idx = (int'(spawn_idx) == N_MOLES - 1) ? '0 : spawn_idx + IDX_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_idx_d  = cur_idx_q;
        prev_idx_d = prev_idx_q;
        timer_d    = timer_q;
        score_d    = score_q;
        lives_d    = lives_q;
        win_d      = win_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SPAWN;
                    score_d = '0;
                    lives_d = 3'(LIVES);
                end
            end
            SPAWN: begin
                cur_idx_d  = spawn_idx;
                prev_idx_d = spawn_idx;
                timer_d    = '0;
                state_d    = UP;
            end
            UP: begin
                timer_d = timer_q + TIMER_W'(1);
                // A wrong whack outranks a simultaneous correct one; a correct
                // whack outranks the timeout.
                if (wrong_hit) begin
                    state_d = MISS;
                end else if (right_hit) begin
                    state_d = HIT;
                end else if (timed_out) begin
                    state_d = MISS;
                end
            end
            HIT: begin
                score_d = score_inc;
                if (score_inc == SCORE_W'(WIN_SCORE)) begin
                    state_d = DONE;
                    win_d   = 1'b1;
                end else begin
                    state_d = SPAWN;
                end
            end
            MISS: begin
                if (lives_q != 3'd0) begin
                    lives_d = lives_q - 3'd1;
                end
                if (lives_q <= 3'd1) begin
                    state_d = DONE;
                    win_d   = 1'b0;
                end else begin
                    state_d = SPAWN;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = SPAWN;
                    win_d   = 1'b0;
                    score_d = '0;
                    lives_d = 3'(LIVES);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Synchroniser and edge history preload from the live switches so that
    // leaving reset never reports a toggle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1_q   <= sw;
            sw_s2_q   <= sw;
            sw_prev_q <= sw;
        end else begin
            sw_s1_q   <= sw_s1_d;
            sw_s2_q   <= sw_s2_d;
            sw_prev_q <= sw_prev_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_idx_q  <= '0;
            prev_idx_q <= '0;
            timer_q    <= '0;
            score_q    <= '0;
            lives_q    <= 3'(LIVES);
            win_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_idx_q  <= cur_idx_d;
            prev_idx_q <= prev_idx_d;
            timer_q    <= timer_d;
            score_q    <= score_d;
            lives_q    <= lives_d;
            win_q      <= win_d;
        end
    end

    always_comb begin
        led = '0;
        if (state_q == UP) begin
            led = cur_mask;
        end else if (state_q == DONE && win_q) begin
            led = '1;
        end
    end

    assign score      = score_q;
    assign lives_left = lives_q;
    assign game_over  = (state_q == DONE);
    assign win        = win_q;

endmodule

// File: tb/tb_mole_game_engine.sv
// Randomised game-play bench: a game-rule model predicts every output change,
// and a negedge monitor matches each DUT output change against it.
module tb_mole_game_engine;

    localparam int          N     = 12;
    localparam int          SW    = 6;
    localparam int          WIN   = 6;
    localparam int          MT    = 20;
    localparam int          LIVES = 3;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          IDXW  = $clog2(N);
    localparam int          OW    = N + SW + 5;
    localparam logic [OW-1:0] RESET_VEC = {{N{1'b0}}, {SW{1'b0}}, 3'(LIVES), 1'b0, 1'b0};

    localparam int P_IDLE = 0, P_PICK = 1, P_UP = 2, P_HIT = 3, P_MISS = 4, P_END = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [N-1:0]  sw;
    logic [N-1:0]  led;
    logic [SW-1:0] score;
    logic [2:0]    lives_left;
    logic          game_over;
    logic          win;

    mole_game_engine #(
        .N_MOLES   (N),
        .SCORE_W   (SW),
        .WIN_SCORE (WIN),
        .MOLE_TIME (MT),
        .LIVES     (LIVES),
        .LFSR_SEED (SEED)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .sw         (sw),
        .led        (led),
        .score      (score),
        .lives_left (lives_left),
        .game_over  (game_over),
        .win        (win)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            c;
        logic [OW-1:0] v;
    } exp_t;

    exp_t          sbq[$];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    bit            mon_en = 1'b0;

    int            m_phase = P_IDLE;
    int            m_cur = 0;
    int            m_prev = 0;
    int            m_timer = 0;
    int            m_score = 0;
    int            m_lives = LIVES;
    bit            m_win = 1'b0;
    logic [15:0]   m_lfsr = SEED;
    logic [N-1:0]  m_a, m_b, m_c;
    logic [OW-1:0] m_last = RESET_VEC;

    function automatic logic [OW-1:0] exp_vec();
        logic [N-1:0] l;
        l = '0;
        if (m_phase == P_UP) l[m_cur] = 1'b1;
        else if (m_phase == P_END && m_win) l = '1;
        return {l, SW'(m_score), 3'(m_lives), (m_phase == P_END), m_win};
    endfunction

    // Game rules applied at one clock edge, using the inputs seen at that edge.
    task automatic model_step();
        logic [N-1:0]  t;
        logic [N-1:0]  mask;
        logic [OW-1:0] v;
        int            idx;
        cyc++;
        if (reset) begin
            m_phase = P_IDLE; m_score = 0; m_lives = LIVES; m_win = 1'b0;
            m_prev = 0; m_cur = 0; m_timer = 0; m_lfsr = SEED;
            m_a = sw; m_b = sw; m_c = sw;
        end else begin
            t = m_b ^ m_c;
            mask = '0;
            mask[m_cur] = 1'b1;
            case (m_phase)
                P_IDLE: if (start) begin m_phase = P_PICK; m_score = 0; m_lives = LIVES; end
                P_PICK: begin
                    idx = int'(m_lfsr % (16'd1 << IDXW)) % N;
                    if (idx == m_prev) idx = (idx + 1) % N;
                    m_cur = idx; m_prev = idx; m_timer = 0; m_phase = P_UP;
                end
                P_UP: begin
                    if ((t & ~mask) != '0) m_phase = P_MISS;
                    else if ((t & mask) != '0) m_phase = P_HIT;
                    else if (m_timer == MT - 1) m_phase = P_MISS;
                    m_timer++;
                end
                P_HIT: begin
                    m_score++;
                    if (m_score == WIN) begin m_phase = P_END; m_win = 1'b1; end
                    else m_phase = P_PICK;
                end
                P_MISS: begin
                    m_lives--;
                    if (m_lives == 0) begin m_phase = P_END; m_win = 1'b0; end
                    else m_phase = P_PICK;
                end
                default: if (start) begin
                    m_phase = P_PICK; m_win = 1'b0; m_score = 0; m_lives = LIVES;
                end
            endcase
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            m_c = m_b; m_b = m_a; m_a = sw;
        end
        v = exp_vec();
        if (v !== m_last) begin
            sbq.push_back('{cyc, v});
            m_last = v;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_reset(input string name);
        logic [OW-1:0] v;
        @(negedge clk);
        v = {led, score, lives_left, game_over, win};
        checks++;
        if (v !== RESET_VEC) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, v, RESET_VEC);
        end
    endtask

    // Monitor: every DUT output change must match the next predicted change,
    // on the same cycle.
    initial begin : monitor
        logic [OW-1:0] seen;
        logic [OW-1:0] v;
        exp_t          e;
        seen = RESET_VEC;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                while (sbq.size() > 0 && sbq[0].c < cyc) begin
                    e = sbq.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL missed_change cyc=%0d got=%h expected=%h@%0d", cyc, seen, e.v, e.c);
                end
                v = {led, score, lives_left, game_over, win};
                if (v !== seen) begin
                    checks++;
                    if (sbq.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_change cyc=%0d got=%h expected=%h", cyc, v, seen);
                    end else begin
                        e = sbq.pop_front();
                        if (e.v !== v || e.c != cyc) begin
                            failures++;
                            $display("FAIL out_change got=%h@%0d expected=%h@%0d", v, cyc, e.v, e.c);
                        end
                    end
                    seen = v;
                end
            end
        end
    end

    // mode 0: mixed random play, 1: never touch, 2: always hit, 3: hit then reset at score 5
    task automatic play_game(input int mode);
        int react, action, w;
        bit done;
        start = 1'b1;
        for (int k = 0; k < 6 && m_phase != P_PICK; k++) tick();
        start = 1'b0;
        react = -1;
        action = 0;
        done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            tick();
            start = ($urandom_range(0, 3) == 0);
            if (m_phase == P_IDLE || m_phase == P_END) begin
                start = 1'b0;
                done = 1'b1;
            end else if (m_phase == P_UP) begin
                if (m_timer == 0) begin
                    action = (mode == 0) ? $urandom_range(0, 9) : ((mode == 1) ? 9 : 0);
                    react = (mode == 0) ? $urandom_range(0, MT + 2) : $urandom_range(0, MT - 3);
                    if (mode >= 2 && $urandom_range(0, 3) == 0) react = MT - 3;
                end
                if (mode == 3 && m_score == 5) begin
                    reset = 1'b1;
                    tick();
                    reset = 1'b0;
                    check_reset("reset_midgame");
                    done = 1'b1;
                end else if (mode == 0 && $urandom_range(0, 199) == 0) begin
                    reset = 1'b1;
                    tick();
                    reset = 1'b0;
                    done = 1'b1;
                end else if (m_timer == react && action != 9) begin
                    w = $urandom_range(0, N - 2);
                    if (w >= m_cur) w++;
                    if (action <= 5 || action == 8) sw[m_cur] = ~sw[m_cur];
                    if (action >= 6) sw[w] = ~sw[w];
                end
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL game_budget got=unfinished expected=finished mode=%0d", mode);
        end
    endtask

    initial begin : driver
        int modes[6] = '{2, 1, 0, 2, 3, 0};
        reset = 1'b1;
        start = 1'b0;
        sw = N'($urandom);
        tick();
        mon_en = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_reset("reset_state");
        for (int g = 0; g < 22; g++) begin
            play_game((g < 6) ? modes[g] : int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 3)) tick();
        end
        repeat (5) tick();
        @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL pending_changes got=%0d expected=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
